xgmii_tx_framer: RTL and testbench

XGMII_TX_FRAMER -- requirements
Module: xgmii_tx_framer

---
 rtl/xgmii_tx_framer.sv | 140 ++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_tx_framer
// Brief    : Beat stream to 64-bit XGMII TX framer (/S/, /T/, IFG, error words)
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_tx_framer #(
  parameter logic [3:0] IFG_WORDS = 4'h1
) (
  input  logic        xgmii_tx_clk,
  input  logic        sys_rst,
  input  logic [63:0] tx_data,
  input  logic [7:0]  tx_keep,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        tx_underrun
);

  localparam logic [63:0] C_IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] C_PRE_D  = 64'hD5555555555555FB;
  localparam logic [63:0] C_ERR_D  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] C_TERM_D = 64'h07070707070707FD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TERM = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_gcnt, w_gcnt_nxt;
  logic [63:0] r_txd, w_txd_nxt;
  logic [7:0]  r_txc, w_txc_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic        w_keep_partial;
  logic [7:0]  w_keep_prev;
  logic [63:0] w_term_d;
  logic [7:0]  w_term_c;

  // A partial last beat must be a contiguous run of 1..7 lanes from lane 0;
  // /T/ lands in the first lane whose lower neighbour still carries data.
  always_comb begin
    w_keep_partial = (tx_keep != 8'h00) && (tx_keep != 8'hFF) &&
                     ((tx_keep & (tx_keep + 8'd1)) == 8'h00);
    w_keep_prev    = {tx_keep[6:0], 1'b0};
    w_term_d       = C_IDLE_D;
    w_term_c       = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (tx_keep[i]) begin
        w_term_d[8*i +: 8] = tx_data[8*i +: 8];
        w_term_c[i]        = 1'b0;
      end else if (w_keep_prev[i]) begin
        w_term_d[8*i +: 8] = 8'hFD;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gcnt_nxt     = r_gcnt;
    w_txd_nxt      = C_IDLE_D;
    w_txc_nxt      = 8'hFF;
    w_underrun_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_gcnt != 4'd0) begin
          w_gcnt_nxt = r_gcnt - 4'd1;
        end else if (tx_valid) begin
          w_txd_nxt   = C_PRE_D;
          w_txc_nxt   = 8'h01;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (!tx_valid) begin
          w_txd_nxt      = C_ERR_D;
          w_underrun_nxt = 1'b1;
          w_state_nxt    = S_DROP;
        end else if (tx_keep == 8'hFF) begin
          w_txd_nxt = tx_data;
          w_txc_nxt = 8'h00;
          if (tx_last) w_state_nxt = S_TERM;
        end else if (tx_last && w_keep_partial) begin
          w_txd_nxt   = w_term_d;
          w_txc_nxt   = w_term_c;
          w_gcnt_nxt  = IFG_WORDS;
          w_state_nxt = S_IDLE;
        end else begin
          w_txd_nxt      = C_ERR_D;
          w_underrun_nxt = 1'b1;
          if (tx_last) begin
            w_gcnt_nxt  = IFG_WORDS;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_TERM: begin
        w_txd_nxt   = C_TERM_D;
        w_gcnt_nxt  = IFG_WORDS;
        w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (tx_valid && tx_last) begin
          w_gcnt_nxt  = IFG_WORDS;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_gcnt     <= 4'd0;
      r_txd      <= C_IDLE_D;
      r_txc      <= 8'hFF;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_txd      <= w_txd_nxt;
      r_txc      <= w_txc_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign tx_ready    = (r_state == S_DATA) || (r_state == S_DROP);
  assign xgmii_txd   = r_txd;
  assign xgmii_txc   = r_txc;
  assign tx_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_framer.sv
`default_nettype none
// Randomized frames against a frame-level model: expected non-idle word list
// per frame plus the preamble timing rule max(gap_edge + IFG + 1, valid_edge).
module tb_xgmii_tx_framer;

  localparam logic [3:0] IFG     = 4'd3;
  localparam int         NFRAMES = 60;
  localparam logic [71:0] IDLEW  = {64'h0707070707070707, 8'hFF};
  localparam logic [71:0] PREW   = {64'hD5555555555555FB, 8'h01};
  localparam logic [71:0] ERRW   = {64'hFEFEFEFEFEFEFEFE, 8'hFF};
  localparam logic [71:0] TERMW  = {64'h07070707070707FD, 8'hFF};

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [63:0] tx_data  = '0;
  logic [7:0]  tx_keep  = '0;
  logic        tx_valid = 1'b0;
  logic        tx_last  = 1'b0;
  logic        tx_ready;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        tx_underrun;

  always #5 clk = ~clk;

  xgmii_tx_framer #(.IFG_WORDS(IFG)) dut (
    .xgmii_tx_clk (clk),
    .sys_rst      (sys_rst),
    .tx_data      (tx_data),
    .tx_keep      (tx_keep),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .xgmii_txd    (xgmii_txd),
    .xgmii_txc    (xgmii_txc),
    .tx_underrun  (tx_underrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of lanes in a contiguous-from-lane-0 partial keep, 0 if not one.
  function automatic int contig_len(input logic [7:0] k);
    int m;
    for (int n = 1; n < 8; n++) begin
      m = (1 << n) - 1;
      if (int'(k) == m) return n;
    end
    return 0;
  endfunction

  logic [71:0] exp_q[$];
  logic [63:0] bd[8];
  logic [7:0]  bk[8];
  int          v_edge[NFRAMES];
  int          g_edge[NFRAMES];
  int          pre_seen = 0;
  bit          mon_en   = 1'b0;

  task automatic model_frame(input int nb, input int bub, output bit full_term);
    logic [63:0] d;
    logic [7:0]  c;
    int          n;
    full_term = 1'b0;
    exp_q.push_back(PREW);
    for (int i = 0; i < nb; i++) begin
      if (i == bub) begin
        exp_q.push_back(ERRW);
        return;
      end
      n = contig_len(bk[i]);
      if (bk[i] == 8'hFF) begin
        exp_q.push_back({bd[i], 8'h00});
        if (i == nb - 1) begin
          exp_q.push_back(TERMW);
          full_term = 1'b1;
        end
      end else if ((i == nb - 1) && (n > 0)) begin
        for (int j = 0; j < 8; j++) begin
          if (j < n)       d[8*j +: 8] = bd[i][8*j +: 8];
          else if (j == n) d[8*j +: 8] = 8'hFD;
          else             d[8*j +: 8] = 8'h07;
          c[j] = (j >= n);
        end
        exp_q.push_back({d, c});
      end else begin
        exp_q.push_back(ERRW);
        return;
      end
    end
  endtask

  task automatic send_frame(input int f, input int gap);
    int nb, bub, sel, t, last_acc;
    bit full_term;
    nb = $urandom_range(1, 5);
    for (int i = 0; i < nb; i++) begin
      bd[i] = {$urandom, $urandom};
      if (i < nb - 1) begin
        bk[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      end else begin
        sel = $urandom_range(0, 5);
        if (sel < 2)       bk[i] = 8'hFF;
        else if (sel < 5)  bk[i] = 8'((1 << $urandom_range(1, 7)) - 1);
        else               bk[i] = 8'($urandom);
      end
    end
    bub = (nb > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb - 1) : -1;
    model_frame(nb, bub, full_term);
    repeat (gap) @(negedge clk);
    last_acc = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == bub) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      tx_data  = bd[i];
      tx_keep  = bk[i];
      tx_last  = (i == nb - 1);
      tx_valid = 1'b1;
      if (i == 0) v_edge[f] = cyc + 1;
      t = 0;
      while (!tx_ready && t < 64) begin
        @(negedge clk);
        t++;
      end
      check_eq("beat_accepted", 72'(t < 64), 72'd1);
      last_acc = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    g_edge[f] = last_acc + (full_term ? 1 : 0);
  endtask

  logic [71:0] m_w, m_e;
  int          m_p;
  always @(negedge clk) begin
    if (mon_en) begin
      m_w = {xgmii_txd, xgmii_txc};
      check_eq("underrun_flag", 72'(tx_underrun), 72'(m_w == ERRW));
      if (m_w != IDLEW) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", m_w, IDLEW);
        end else begin
          m_e = exp_q.pop_front();
          check_eq("word", m_w, m_e);
          if (m_w == PREW && pre_seen < NFRAMES) begin
            m_p = (pre_seen == 0) ? v_edge[0]
                : imax(g_edge[pre_seen-1] + int'(IFG) + 1, v_edge[pre_seen]);
            check_eq("preamble_edge", 72'(cyc), 72'(m_p));
            pre_seen++;
          end
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b1;
    #7;
    check_eq("reset_word", {xgmii_txd, xgmii_txc}, IDLEW);
    check_eq("reset_ready", 72'(tx_ready), 72'd0);
    check_eq("reset_underrun", 72'(tx_underrun), 72'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk);

    for (int f = 0; f < NFRAMES; f++) send_frame(f, $urandom_range(0, 6));
    repeat (30) @(negedge clk);
    check_eq("queue_drained", 72'(exp_q.size()), 72'd0);
    check_eq("preambles_seen", 72'(pre_seen), 72'(NFRAMES));

    // Async reset in the middle of a frame.
    mon_en   = 1'b0;
    tx_data  = 64'h1122334455667788;
    tx_keep  = 8'hFF;
    tx_last  = 1'b0;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midframe_ready", 72'(tx_ready), 72'd1);
    #2 sys_rst = 1'b1;
    #1;
    check_eq("async_rst_word", {xgmii_txd, xgmii_txc}, IDLEW);
    check_eq("async_rst_ready", 72'(tx_ready), 72'd0);
    check_eq("async_rst_underrun", 72'(tx_underrun), 72'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    sys_rst  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_idle", {xgmii_txd, xgmii_txc}, IDLEW);
      check_eq("post_rst_underrun", 72'(tx_underrun), 72'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
